// File: rtl/piramide_pkg.sv
// Shared types and constants for the pyramid-stream monitor.
package piramide_pkg;

   typedef enum logic [1:0] {SYNC, RISE, FALL} pmon_state_t;
   typedef enum logic [1:0] {STEP_UP, STEP_DOWN, STEP_BAD} step_t;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   localparam int ERR_COUNT_W = 8;

endpackage

// File: rtl/piramide_monitor_if.sv
// Sample stream in, measurement results out; the producer side is the master.
interface piramide_monitor_if #(
   parameter int W        = 4,
   parameter int PERIOD_W = 8
);
   import piramide_pkg::*;

   logic [W-1:0]           sample;
   logic                   sample_valid;
   logic                   dir;
   logic [W-1:0]           peak_value;
   logic                   peak_valid;
   logic [PERIOD_W-1:0]    period;
   logic                   period_valid;
   logic                   locked;
   logic                   err;
   logic [ERR_COUNT_W-1:0] err_count;

   modport master (
      output sample, sample_valid,
      input  dir, peak_value, peak_valid, period, period_valid, locked, err, err_count
   );

   modport slave (
      input  sample, sample_valid,
      output dir, peak_value, peak_valid, period, period_valid, locked, err, err_count
   );

endinterface

// File: rtl/pmon_step_classify.sv
// Classifies one stream step as +1, -1 or illegal, using W+1 bits so the
// top value never wraps back to zero.
module pmon_step_classify
   import piramide_pkg::*;
#(
   parameter int W = 4
) (
   input  logic [W-1:0] prev,
   input  logic [W-1:0] sample,
   output step_t        step
);

   localparam logic [W:0] ONE = (W+1)'(1);

   logic [W:0] prev_x;
   logic [W:0] sample_x;

   always_comb begin
      prev_x   = {1'b0, prev};
      sample_x = {1'b0, sample};
      step     = STEP_BAD;
      if (sample_x == prev_x + ONE) begin
         step = STEP_UP;
      end else if (sample_x + ONE == prev_x) begin
         step = STEP_DOWN;
      end
   end

endmodule

// File: rtl/piramide_monitor.sv
// Receiving-end checker for a triangle count stream: tracks ramp direction,
// measures peaks and valley-to-valley periods, declares lock, flags bad steps.
module piramide_monitor
   import piramide_pkg::*;
#(
   parameter int W            = 4,
   parameter int PERIOD_W     = 8,
   parameter int LOCK_PERIODS = 2
) (
   input logic               clk,
   input logic               rst,
   piramide_monitor_if.slave mon
);

   localparam int                     CLEAN_W    = $clog2(LOCK_PERIODS + 1);
   localparam logic [CLEAN_W-1:0]     CLEAN_MAX  = CLEAN_W'(LOCK_PERIODS);
   localparam logic [PERIOD_W-1:0]    PERIOD_MAX = '1;
   localparam logic [ERR_COUNT_W-1:0] ERR_MAX    = '1;

   pmon_state_t            state_q, state_d;
   logic [W-1:0]           prev_q, prev_d;
   logic [W-1:0]           peak_value_q, peak_value_d;
   logic                   peak_valid_q, peak_valid_d;
   logic [PERIOD_W-1:0]    period_q, period_d;
   logic                   period_valid_q, period_valid_d;
   logic                   locked_q, locked_d;
   logic                   err_q, err_d;
   logic [ERR_COUNT_W-1:0] err_count_q, err_count_d;
   logic [PERIOD_W-1:0]    cnt_q, cnt_d;
   logic [CLEAN_W-1:0]     clean_q, clean_d;
   logic [W-1:0]           last_peak_q, last_peak_d;

   step_t               step;
   logic                bad;
   logic [PERIOD_W-1:0] cnt_inc;
   logic [CLEAN_W-1:0]  clean_inc;

   pmon_step_classify #(.W(W)) u_classify (
      .prev   (prev_q),
      .sample (mon.sample),
      .step   (step)
   );

   // Both counters saturate; clean only needs to reach the lock threshold.
   assign cnt_inc   = (cnt_q == PERIOD_MAX) ? cnt_q : cnt_q + PERIOD_W'(1);
   assign clean_inc = (clean_q == CLEAN_MAX) ? clean_q : clean_q + CLEAN_W'(1);

   always_comb begin
      // NOTE: every _d gets its hold value first, so no branch can infer a latch.
      state_d        = state_q;
      prev_d         = prev_q;
      peak_value_d   = peak_value_q;
      peak_valid_d   = 1'b0;
      period_d       = period_q;
      period_valid_d = 1'b0;
      locked_d       = locked_q;
      err_d          = 1'b0;
      err_count_d    = err_count_q;
      cnt_d          = cnt_q;
      clean_d        = clean_q;
      last_peak_d    = last_peak_q;
      bad            = 1'b0;

      if (mon.sample_valid) begin
         prev_d = mon.sample;
         unique case (state_q)
            SYNC: begin
               if (mon.sample == '0) begin
                  state_d = RISE;
                  cnt_d   = '0;
               end
            end
            RISE: begin
               unique case (step)
                  STEP_UP: cnt_d = cnt_inc;
                  STEP_DOWN: begin
                     peak_value_d = prev_q;
                     peak_valid_d = 1'b1;
                     cnt_d        = cnt_inc;
                     state_d      = FALL;
                  end
                  default: bad = 1'b1;
               endcase
            end
            FALL: begin
               if (step != STEP_DOWN) begin
                  bad = 1'b1;
               end else if (mon.sample != '0) begin
                  cnt_d = cnt_inc;
               end else begin
                  // Valley: close the period and grade it against the last one.
                  period_d       = cnt_inc;
                  period_valid_d = 1'b1;
                  cnt_d          = '0;
                  state_d        = RISE;
                  clean_d        = (peak_value_q == last_peak_q) ? clean_inc : CLEAN_W'(1);
                  last_peak_d    = peak_value_q;
                  locked_d       = (clean_d >= CLEAN_MAX);
               end
            end
            default: state_d = SYNC;
         endcase

         if (bad) begin
            err_d       = 1'b1;
            err_count_d = (err_count_q == ERR_MAX) ? err_count_q : err_count_q + ERR_COUNT_W'(1);
            locked_d    = 1'b0;
            clean_d     = '0;
            state_d     = SYNC;
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of order.
      if (rst) begin
         state_q        <= SYNC;
         prev_q         <= '0;
         peak_value_q   <= '0;
         peak_valid_q   <= 1'b0;
         period_q       <= '0;
         period_valid_q <= 1'b0;
         locked_q       <= 1'b0;
         err_q          <= 1'b0;
         err_count_q    <= '0;
         cnt_q          <= '0;
         clean_q        <= '0;
         last_peak_q    <= '0;
      end else begin
         state_q        <= state_d;
         prev_q         <= prev_d;
         peak_value_q   <= peak_value_d;
         peak_valid_q   <= peak_valid_d;
         period_q       <= period_d;
         period_valid_q <= period_valid_d;
         locked_q       <= locked_d;
         err_q          <= err_d;
         err_count_q    <= err_count_d;
         cnt_q          <= cnt_d;
         clean_q        <= clean_d;
         last_peak_q    <= last_peak_d;
      end
   end

   assign mon.dir          = (state_q == FALL) ? DIR_DOWN : DIR_UP;
   assign mon.peak_value   = peak_value_q;
   assign mon.peak_valid   = peak_valid_q;
   assign mon.period       = period_q;
   assign mon.period_valid = period_valid_q;
   assign mon.locked       = locked_q;
   assign mon.err          = err_q;
   assign mon.err_count    = err_count_q;

endmodule

// File: tb/tb_piramide_monitor.sv
// Scoreboard bench for piramide_monitor: stimulus pushes expected pulse events,
// a monitor pops and compares whenever the DUT pulses.
module tb_piramide_monitor;
   import piramide_pkg::*;

   localparam int W    = 4;
   localparam int PW   = 8;
   localparam int LOCK = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   piramide_monitor_if #(.W(W), .PERIOD_W(PW)) bus ();

   piramide_monitor #(.W(W), .PERIOD_W(PW), .LOCK_PERIODS(LOCK)) dut (
      .clk (clk),
      .rst (rst),
      .mon (bus.slave)
   );

   typedef struct {
      int cyc;
      bit peak_v;
      int peak;
      bit period_v;
      int period;
      bit err;
      int err_count;
      bit locked;
      bit dir;
   } ev_t;

   ev_t exp_q[$];
   int  tests = 0;
   int  fails = 0;
   int  cyc   = 0;
   int  gap_pct = 0;
   int  corrupt_pct = 0;
   bit  gap_mode = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: tracks the stream by its differences, not by DUT state.
   bit m_synced, m_falling, m_locked;
   int m_prev, m_cnt, m_peak, m_last_peak, m_clean, m_errc, m_period;

   function automatic int cap(int v, int mx);
      return (v > mx) ? mx : v;
   endfunction

   task automatic model_reset();
      m_synced = 0; m_falling = 0; m_locked = 0;
      m_prev = 0; m_cnt = 0; m_peak = 0; m_last_peak = 0;
      m_clean = 0; m_errc = 0; m_period = 0;
   endtask

   task automatic model_step(int s);
      ev_t e = '{default: 0};
      bit  ev  = 0;
      bit  bad = 0;
      int  d   = s - m_prev;
      if (!m_synced) begin
         if (s == 0) begin
            m_synced = 1; m_falling = 0; m_cnt = 0;
         end
      end else if (!m_falling) begin
         if (d == 1) m_cnt = cap(m_cnt + 1, 255);
         else if (d == -1) begin
            m_peak = m_prev; m_cnt = cap(m_cnt + 1, 255); m_falling = 1;
            ev = 1; e.peak_v = 1;
         end else bad = 1;
      end else begin
         if (d == -1 && s == 0) begin
            m_period = cap(m_cnt + 1, 255); m_cnt = 0; m_falling = 0;
            m_clean = (m_peak == m_last_peak) ? m_clean + 1 : 1;
            m_last_peak = m_peak;
            m_locked = (m_clean >= LOCK);
            ev = 1; e.period_v = 1;
         end else if (d == -1) m_cnt = cap(m_cnt + 1, 255);
         else bad = 1;
      end
      if (bad) begin
         m_errc = cap(m_errc + 1, 255);
         m_locked = 0; m_clean = 0; m_synced = 0; m_falling = 0;
         ev = 1; e.err = 1;
      end
      m_prev = s;
      if (ev) begin
         e.cyc = cyc + 1; e.peak = m_peak; e.period = m_period;
         e.err_count = m_errc; e.locked = m_locked; e.dir = m_falling;
         exp_q.push_back(e);
      end
   endtask

   task automatic idle();
      @(negedge clk);
      bus.sample_valid = 1'b0;
      bus.sample = W'($urandom_range(15));
   endtask

   task automatic send(int s_in);
      int s = s_in;
      if (gap_mode || ($urandom_range(99) < gap_pct)) idle();
      if ($urandom_range(99) < corrupt_pct) s = $urandom_range(15);
      @(negedge clk);
      bus.sample = W'(s);
      bus.sample_valid = 1'b1;
      model_step(s);
   endtask

   // One generator period without its closing zero: 0..mx..1.
   task automatic tri_period(int mx);
      for (int v = 0; v <= mx; v++) send(v);
      for (int v = mx - 1; v >= 1; v--) send(v);
   endtask

   task automatic check_reset_outputs(string tag);
      check({tag, "_dir"},          bus.dir,          0);
      check({tag, "_peak_value"},   bus.peak_value,   0);
      check({tag, "_peak_valid"},   bus.peak_valid,   0);
      check({tag, "_period"},       bus.period,       0);
      check({tag, "_period_valid"}, bus.period_valid, 0);
      check({tag, "_locked"},       bus.locked,       0);
      check({tag, "_err"},          bus.err,          0);
      check({tag, "_err_count"},    bus.err_count,    0);
   endtask

   task automatic do_reset(string tag);
      idle(); idle();
      @(negedge clk);
      rst = 1'b1;
      bus.sample_valid = 1'b0;
      model_reset();
      @(negedge clk);
      check_reset_outputs(tag);
      rst = 1'b0;
   endtask

   // Scoreboard monitor.
   always @(negedge clk) begin
      ev_t e;
      if (!rst) begin
         if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            tests++; fails++;
            $display("FAIL missing_pulse: no pulse seen, expected one at cycle %0d", e.cyc);
         end
         if (bus.peak_valid || bus.period_valid || bus.err) begin
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
               e = exp_q.pop_front();
               check("peak_valid",   bus.peak_valid,   e.peak_v);
               check("peak_value",   bus.peak_value,   e.peak);
               check("period_valid", bus.period_valid, e.period_v);
               check("period",       bus.period,       e.period);
               check("err",          bus.err,          e.err);
               check("err_count",    bus.err_count,    e.err_count);
               check("locked",       bus.locked,       e.locked);
               check("dir",          bus.dir,          e.dir);
            end else begin
               tests++; fails++;
               $display("FAIL unexpected_pulse: peak_valid=%0d period_valid=%0d err=%0d, expected none at cycle %0d",
                        bus.peak_valid, bus.period_valid, bus.err, cyc);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      bus.sample = '0;
      bus.sample_valid = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check_reset_outputs("init");
      rst = 1'b0;

      // Clean max=5 stream: peaks 5, periods 10, lock after second valley.
      for (int p = 0; p < 3; p++) tri_period(5);
      send(0);
      idle(); idle();
      check("max5_locked", bus.locked, m_locked);

      // Same stream with sample_valid toggling.
      do_reset("r1");
      gap_mode = 1;
      for (int p = 0; p < 3; p++) tri_period(5);
      send(0);
      gap_mode = 0;
      idle(); idle();
      check("gap_locked", bus.locked, m_locked);

      // Illegal jump, then a short clean period of 4.
      do_reset("r2");
      send(0); send(1); send(3);
      send(0); send(1); send(2); send(1); send(0);

      // Wrap from 15 to 0 is illegal.
      do_reset("r3");
      tri_period(15); send(0);
      tri_period(15); send(0);
      for (int v = 1; v <= 15; v++) send(v);
      send(0);

      // Alternating peaks never lock.
      do_reset("r4");
      for (int p = 0; p < 3; p++) begin
         tri_period(5);
         tri_period(6);
      end
      send(0);
      idle(); idle();
      check("alt_locked", bus.locked, m_locked);

      // Reset mid-fall while locked, then 3,2 must stay quiet.
      do_reset("r5");
      tri_period(5); tri_period(5); send(0);
      for (int v = 1; v <= 5; v++) send(v);
      send(4); send(3);
      idle(); idle();
      check("pre_rst_locked", bus.locked, m_locked);
      check("pre_rst_dir", bus.dir, m_falling);
      do_reset("mid");
      send(3); send(2);
      idle(); idle();
      check("post_rst_dir", bus.dir, 0);
      check("post_rst_err_count", bus.err_count, m_errc);

      // Error counter saturation.
      do_reset("r6");
      for (int i = 0; i < 260; i++) begin
         send(0); send(2);
      end
      idle(); idle();
      check("err_count_sat", bus.err_count, m_errc);

      // Randomized streams with gaps and occasional corruption.
      do_reset("r7");
      gap_pct = 30;
      corrupt_pct = 3;
      begin
         int mx = 5;
         for (int p = 0; p < 60; p++) begin
            if ($urandom_range(3) == 0) mx = $urandom_range(15);
            tri_period(mx);
         end
      end
      send(0);
      gap_pct = 0;
      corrupt_pct = 0;

      repeat (4) idle();
      check("leftover_events", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/piramide_monitor.md
Name: piramide_monitor

Overview:
- Receiving-end checker for the triangle ("pyramid") count stream that the up/down counter generator produces: 0,1,…,max,max-1,…,1,0,1,…
- Tracks the ramp direction and reports each peak value and each full period length.
- Declares lock after repeated clean periods; flags any step that is not a legal ±1 ramp step.
- Sits downstream of the generator, or of any producer of the same stream, as a self-check and measurement block.

Parameters:
- W, 4, sample width; must match the generator output width.
- PERIOD_W, 8, width of the period counter.
- LOCK_PERIODS, 2, consecutive clean, equal-peak periods required to assert lock.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- sample  input  W  incoming pyramid value
- sample_valid  input  1  sample is captured only on cycles where this is high
- dir  output  1  0 = rising, 1 = falling; reflects the current state
- peak_value  output  W  last detected peak
- peak_valid  output  1  one-cycle pulse when peak_value updates
- period  output  PERIOD_W  samples between consecutive valleys
- period_valid  output  1  one-cycle pulse when period updates
- locked  output  1  stream is stable
- err  output  1  one-cycle pulse on an illegal step
- err_count  output  8  saturating error count, sticky until reset

Behaviour:
- One clock domain. Reset is synchronous and active-high, named clk/rst as in the codebase.
- Reset values:
  - state = SYNC; dir = 0; prev = 0.
  - peak_value = 0, period = 0, locked = 0, err_count = 0.
  - All pulses (peak_valid, period_valid, err) = 0.
  - Internal period counter and clean-period counter = 0.
- Cycles with sample_valid = 0: no state change, all counters hold, all pulses low.
- Step classification uses W+1-bit arithmetic, with no modular wrap:
  - UP when sample == prev + 1.
  - DOWN when sample + 1 == prev.
  - Anything else is BAD. This includes prev = 2^W-1 followed by sample = 0.
- prev <= sample on every valid cycle.
- States:
  - SYNC: wait for sample == 0, then go to RISE and set period counter = 0. Other values: stay in SYNC, no err.
  - RISE (dir = 0):
    - UP: period counter + 1; stay.
    - DOWN: peak_value <= prev, peak_valid pulse; period counter + 1; go to FALL.
    - BAD: error action.
  - FALL (dir = 1):
    - DOWN with sample != 0: period counter + 1; stay.
    - DOWN with sample == 0 (valley): period <= counter + 1, period_valid pulse; counter <= 0; go to RISE.
    - UP or BAD: error action.
- A repeated value (a step of 0) is BAD in both RISE and FALL. A generator with max = 0 therefore never locks.
- Error action:
  - err pulse; err_count + 1, saturating at 255.
  - locked <= 0; clean-period counter <= 0; state <= SYNC.
  - The offending sample is stored as prev but not used for sync. Sync is checked from the next valid sample.
- Period counter saturates at 2^PERIOD_W-1 and does not wrap.
- Lock rule, evaluated at each valley:
  - If the peak of this period equals the previous period's peak: clean counter + 1.
  - Otherwise: clean counter = 1.
  - locked <= 1 when clean counter ≥ LOCK_PERIODS.
  - A peak mismatch is not an error, but it clears locked.
- Latency: every output is registered. It reflects the valid sample captured at edge N and is visible after edge N.
- Reset asserted mid-stream: all state returns to reset values at that edge. Re-sync requires a fresh 0.

Decomposition:
- Package piramide_pkg holds:
  - typedef enum logic [1:0] {SYNC, RISE, FALL} pmon_state_t.
  - typedef enum logic [1:0] {STEP_UP, STEP_DOWN, STEP_BAD} step_t.
  - Constants DIR_UP = 1'b0 and DIR_DOWN = 1'b1.
- One natural sub-module: pmon_step_classify, combinational, taking (prev, sample) and returning step_t. The FSM and counters stay in piramide_monitor.

Test Plan:
- W=4, drive the generator stream with max=5: 0,1,2,3,4,5,4,3,2,1,0,… on consecutive cycles.
  - peak_valid with peak_value=5 after the first sample 4.
  - period_valid with period=10 after each 0.
  - locked=1 after the second valley following sync.
- Same stream with sample_valid toggling 1,0,1,0.
  - Identical peak and period values.
  - Pulses occur only after valid cycles.
- Stream 0,1,3: err pulse after sample 3, err_count=1, state SYNC. A subsequent 0,1,2,1,0 gives period=4.
- Max=15 wrap case: …,14,15,0. Sample 0 after 15 is BAD; err=1 and locked drops.
- Peaks alternate 5 then 6 across periods.
  - No err pulses.
  - locked stays 0.
  - peak_value alternates 5/6.
- Assert rst mid-FALL while locked=1: next cycle all outputs equal reset values. Stream 3,2 afterwards stays in SYNC with no err.
